// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write queue.
//   AWL_DEF   : default register address width
//   DWL_DEF   : default register data width
//   DEPTH_DEF : default number of queue entries (power of two, >= 2)
//   rf_entry_t: one queued write (address, data) at the default widths
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int AWL_DEF   = 5;
    localparam int DWL_DEF   = 32;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [AWL_DEF-1:0] addr;
        logic [DWL_DEF-1:0] data;
    } rf_entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// ---------------------------------------------------------------------------
// rf_write_queue_if
// Bundles every non-clock/reset signal of the register-file write queue.
//   master modport : writeback stage / register file / decode side
//                    (drives WRV, WRA, WRD, HOLD, LKA1, LKA2)
//   slave modport  : the queue itself
//                    (drives WRRDY, RFWE, RFWA, RFWD, LKHIT1/2, LKD1/2, COUNT)
// ---------------------------------------------------------------------------
interface rf_write_queue_if
    import rf_pkg::*;
#(
    parameter int AWL   = AWL_DEF,
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic           WRV;
    logic [AWL-1:0] WRA;
    logic [DWL-1:0] WRD;
    logic           WRRDY;
    logic           HOLD;
    logic           RFWE;
    logic [AWL-1:0] RFWA;
    logic [DWL-1:0] RFWD;
    logic [AWL-1:0] LKA1;
    logic [AWL-1:0] LKA2;
    logic           LKHIT1;
    logic           LKHIT2;
    logic [DWL-1:0] LKD1;
    logic [DWL-1:0] LKD2;
    logic [CW-1:0]  COUNT;

    modport master (
        output WRV, WRA, WRD, HOLD, LKA1, LKA2,
        input  WRRDY, RFWE, RFWA, RFWD, LKHIT1, LKHIT2, LKD1, LKD2, COUNT
    );

    modport slave (
        input  WRV, WRA, WRD, HOLD, LKA1, LKA2,
        output WRRDY, RFWE, RFWA, RFWD, LKHIT1, LKHIT2, LKD1, LKD2, COUNT
    );

endinterface

// File: rtl/rf_wq_lookup.sv
// ---------------------------------------------------------------------------
// rf_wq_lookup
// Searches the queued entries for a pending write to one lookup address and
// returns the data of the youngest match.
//   entryAddr_i : address field of every storage slot
//   entryData_i : data field of every storage slot
//   head_i      : slot index of the oldest valid entry
//   count_i     : number of valid entries
//   lkAddr_i    : address being looked up (address 0 never hits)
//   hit_o       : a valid entry matches lkAddr_i
//   data_o      : data of the youngest matching entry, else 0
// ---------------------------------------------------------------------------
module rf_wq_lookup
    import rf_pkg::*;
#(
    parameter int AWL   = AWL_DEF,
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic [DEPTH-1:0][AWL-1:0]   entryAddr_i,
    input  logic [DEPTH-1:0][DWL-1:0]   entryData_i,
    input  logic [$clog2(DEPTH)-1:0]    head_i,
    input  logic [$clog2(DEPTH):0]      count_i,
    input  logic [AWL-1:0]              lkAddr_i,
    output logic                        hit_o,
    output logic [DWL-1:0]              data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] slotIdx;

    // Walk from oldest to youngest so a later match overrides an earlier
    // one, leaving the youngest matching entry's data on the output.
    always_comb begin
        hit_o   = 1'b0;
        data_o  = '0;
        slotIdx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slotIdx = head_i + PW'(k);
            if ((CW'(k) < count_i) && (lkAddr_i != '0) &&
                (entryAddr_i[slotIdx] == lkAddr_i)) begin
                hit_o  = 1'b1;
                data_o = entryData_i[slotIdx];
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// ---------------------------------------------------------------------------
// rf_write_queue
// Small FIFO that buffers writeback-stage register writes and drains them
// into the register file write port whenever that port is free.
//   CLK    : clock, all state changes on its rising edge
//   RST_N  : asynchronous active-low reset, empties the queue immediately
//   bus    : rf_write_queue_if.slave
//            WRV/WRA/WRD/WRRDY : request handshake from writeback
//            HOLD              : register file port busy, stop draining
//            RFWE/RFWA/RFWD    : register file write port (head entry)
//            LKA1/2, LKHIT1/2, LKD1/2 : pending-write lookup for decode
//            COUNT             : number of valid entries
// Configuration macro RF_WRITE_QUEUE_LOOKUP_EN: when defined, the lookup
// logic is built; otherwise LKHIT1/2 and LKD1/2 are tied to 0.
// ---------------------------------------------------------------------------
module rf_write_queue
    import rf_pkg::*;
#(
    parameter int AWL   = AWL_DEF,
    parameter int DWL   = DWL_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    rf_write_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AWL-1:0] addrMem_q;
    logic [DEPTH-1:0][DWL-1:0] dataMem_q;
    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;

    logic wrRdy;
    logic pushEn;
    logic popEn;

    // Writes to register 0 complete the handshake but are dropped, since
    // that register is hard-wired and would only waste a slot.
    assign wrRdy  = (count_q < CW'(DEPTH));
    assign pushEn = bus.WRV & wrRdy & (bus.WRA != '0);
    assign popEn  = (count_q != '0) & ~bus.HOLD;

    // Pointers wrap naturally because their width is exactly log2(DEPTH).
    always_comb begin
        head_d  = popEn  ? head_q + PW'(1) : head_q;
        tail_d  = pushEn ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(pushEn) - CW'(popEn);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            addrMem_q <= '0;
            dataMem_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pushEn) begin
                addrMem_q[tail_q] <= bus.WRA;
                dataMem_q[tail_q] <= bus.WRD;
            end
        end
    end

    // The write port shows the head entry combinationally so a request
    // accepted on one edge is written on the very next edge.
    assign bus.WRRDY = wrRdy;
    assign bus.RFWE  = popEn;
    assign bus.RFWA  = (count_q != '0) ? addrMem_q[head_q] : '0;
    assign bus.RFWD  = (count_q != '0) ? dataMem_q[head_q] : '0;
    assign bus.COUNT = count_q;

`ifdef RF_WRITE_QUEUE_LOOKUP_EN
    rf_wq_lookup #(
        .AWL   (AWL),
        .DWL   (DWL),
        .DEPTH (DEPTH)
    ) u_lookup1 (
        .entryAddr_i (addrMem_q),
        .entryData_i (dataMem_q),
        .head_i      (head_q),
        .count_i     (count_q),
        .lkAddr_i    (bus.LKA1),
        .hit_o       (bus.LKHIT1),
        .data_o      (bus.LKD1)
    );

    rf_wq_lookup #(
        .AWL   (AWL),
        .DWL   (DWL),
        .DEPTH (DEPTH)
    ) u_lookup2 (
        .entryAddr_i (addrMem_q),
        .entryData_i (dataMem_q),
        .head_i      (head_q),
        .count_i     (count_q),
        .lkAddr_i    (bus.LKA2),
        .hit_o       (bus.LKHIT2),
        .data_o      (bus.LKD2)
    );
`else
    // Lookup addresses are deliberately ignored in this build.
    logic unusedLookup;
    assign unusedLookup = ^{bus.LKA1, bus.LKA2};

    assign bus.LKHIT1 = 1'b0;
    assign bus.LKHIT2 = 1'b0;
    assign bus.LKD1   = '0;
    assign bus.LKD2   = '0;
`endif

endmodule

// File: doc/rf_write_queue.md
RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

Interface
REQ-001 SHALL have parameter AWL, default 5, meaning register address width.
REQ-002 SHALL have parameter DWL, default 32, meaning register data width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-004 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port WRV  input  1  write request valid from the writeback stage.
REQ-007 SHALL have port WRA  input  AWL  write request register address.
REQ-008 SHALL have port WRD  input  DWL  write request data.
REQ-009 SHALL have port WRRDY  output  1  queue can accept a request this cycle.
REQ-010 SHALL have port HOLD  input  1  register file write port unavailable; suppresses draining.
REQ-011 SHALL have port RFWE  output  1  register file write enable.
REQ-012 SHALL have port RFWA  output  AWL  register file write address.
REQ-013 SHALL have port RFWD  output  DWL  register file write data.
REQ-014 SHALL have ports LKA1, LKA2  input  AWL  lookup addresses (decode-stage read addresses).
REQ-015 SHALL have ports LKHIT1, LKHIT2  output  1  lookup address has a pending queued write.
REQ-016 SHALL have ports LKD1, LKD2  output  DWL  data of the youngest pending write to the lookup address.
REQ-017 SHALL have port COUNT  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-018 SHALL accept a request on a rising edge when WRV and WRRDY are both 1.
REQ-019 SHALL drive WRRDY = (COUNT < DEPTH) with no dependence on WRV or HOLD.
REQ-020 SHALL complete the handshake for an accepted request with WRA == 0 without enqueuing it.
REQ-021 SHALL drive RFWE = (COUNT != 0) & ~HOLD, with RFWA/RFWD taken combinationally from the head entry.
REQ-022 SHALL pop the head entry on every rising edge where RFWE is 1.
REQ-023 SHALL give one-cycle latency: request accepted at edge N appears on RFWE/RFWA/RFWD in cycle after N (if queue empty, HOLD=0) and is written at edge N+1.
REQ-024 SHALL preserve FIFO order; two writes to the same address reach the register file oldest first.
REQ-025 SHALL handle simultaneous push and pop in one edge with COUNT unchanged, including when COUNT == DEPTH is not possible for push (WRRDY=0).
REQ-026 SHALL wrap head and tail pointers modulo DEPTH.
REQ-027 SHALL drive RFWA and RFWD to 0 when COUNT == 0.
REQ-028 SHALL compute LKHITn = 1 iff some valid entry has address == LKAn and LKAn != 0; LKDn = data of the youngest such entry, else 0.
REQ-029 SHALL exclude the same-cycle input request (WRV/WRA/WRD) from lookup; lookup covers queued entries only.

Reset
REQ-030 SHALL on RST_N low immediately clear all entries, pointers and COUNT to 0, giving RFWE=0, RFWA=0, RFWD=0, WRRDY=1, LKHIT1/2=0, LKD1/2=0.
REQ-031 SHALL discard queued writes on reset mid-operation; no partial write is issued after RST_N falls.

Configuration
REQ-032 SHALL compile lookup logic only when macro RF_WRITE_QUEUE_LOOKUP_EN is defined.
REQ-033 SHALL, without RF_WRITE_QUEUE_LOOKUP_EN, keep all ports but tie LKHIT1/2 and LKD1/2 to 0; queue behaviour is unchanged.

Structure
REQ-034 SHALL place default AWL/DWL/DEPTH constants and the entry record type (address, data) in shared package rf_pkg.
REQ-035 SHALL implement the lookup as one sub-module rf_wq_lookup, instantiated twice (one per lookup port).

Verification
REQ-036 SHALL test: after reset, WRV=1 WRA=3 WRD=0xA5 one cycle, HOLD=0 -> next cycle RFWE=1 RFWA=3 RFWD=0xA5, COUNT=0 after following edge.
REQ-037 SHALL test: HOLD=1, push addr 1..4 data 0x11..0x44 -> WRRDY=0 at COUNT=4; HOLD=0 -> RFWA 1,2,3,4 in four consecutive cycles.
REQ-038 SHALL test: HOLD=1, push (5,0x10) then (5,0x20), LKA1=5 -> LKHIT1=1 LKD1=0x20; LKA2=6 -> LKHIT2=0 LKD2=0.
REQ-039 SHALL test: push WRA=0 WRD=0xFF -> WRRDY handshake completes, COUNT stays 0, RFWE stays 0, LKA1=0 -> LKHIT1=0.
REQ-040 SHALL test: COUNT=3 with HOLD=1, drop RST_N mid-cycle -> RFWE=0, COUNT=0, WRRDY=1 before next clock edge.
REQ-041 SHALL test: COUNT=2, HOLD=0, WRV=1 every cycle for 10 cycles -> COUNT stays 2, pointers wrap, write order matches push order.
